viterbi_err_channel: RTL and testbench

- Parametrised error-injecting channel between the convolutional encoder output and the Viterbi decoder input in the tx/rx harness.
- Generalises fixed "flip a bit for the first few words" injection to any symbol width, with four selectable modes: pass-through, index window, LFSR random, LFSR-triggered burst.
- Keeps saturating symbol and bad-bit counters so the bench reads the actual channel bit error count directly.

---
 rtl/viterbi_err_channel.sv | 201 ++++++++++++++++++++
 tb/tb_viterbi_err_channel.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_err_channel.sv
// ---------------------------------------------------------------------------
// viterbi_err_channel
//
// Error-injecting channel between the convolutional encoder and the Viterbi
// decoder. Each valid symbol is registered (1 clk latency) and XORed with an
// error pattern chosen by one of four modes:
//   0 pass-through, 1 index window, 2 LFSR random, 3 LFSR-triggered burst.
// Saturating counters report symbols accepted and bits actually flipped.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   valid_i, sym_i  encoder symbol stream
//   mode_i          injection mode, sampled on each valid_i
//   bit_mask_i      bits eligible for corruption
//   thresh_i        random trigger threshold (trigger when lfsr <= thresh_i)
//   burst_len_i     burst length in symbols (0 behaves as 1)
//   win_start_i     first corrupted symbol index (window mode)
//   win_len_i       number of corrupted symbols (window mode)
//   clr_i           synchronous clear of counters, index, LFSR, burst state
//   valid_o, sym_o  corrupted symbol stream, err_o = applied error pattern
//   sym_ct_o        valid symbols accepted since reset/clear
//   bad_bit_ct_o    total flipped bits
//   sat_o           sticky: either counter has saturated
// ---------------------------------------------------------------------------
module viterbi_err_channel #(
  parameter int          SYMW = 2,
  parameter int          CNTW = 32,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [SYMW-1:0] sym_i,
  input  logic [1:0]      mode_i,
  input  logic [SYMW-1:0] bit_mask_i,
  input  logic [15:0]     thresh_i,
  input  logic [3:0]      burst_len_i,
  input  logic [CNTW-1:0] win_start_i,
  input  logic [CNTW-1:0] win_len_i,
  input  logic            clr_i,
  output logic            valid_o,
  output logic [SYMW-1:0] sym_o,
  output logic [SYMW-1:0] err_o,
  output logic [CNTW-1:0] sym_ct_o,
  output logic [CNTW-1:0] bad_bit_ct_o,
  output logic            sat_o
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_BURST = 1'b1} state_t;

  // An all-zero seed would lock the LFSR, so fall back to the default.
  localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_WINDOW = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [1:0] MODE_BURST  = 2'd3;

  // Registered state
  logic [15:0]     r_lfsr;
  state_t          r_state;
  logic [3:0]      r_rem;
  logic            r_valid;
  logic [SYMW-1:0] r_sym;
  logic [SYMW-1:0] r_err;
  logic [CNTW-1:0] r_sym_ct;
  logic [CNTW-1:0] r_bad_ct;
  logic            r_sat;

  // Combinational decisions for the current symbol
  logic [15:0]     w_lfsr_next;
  logic [SYMW-1:0] w_cand;
  logic [SYMW-1:0] w_low_bit;
  logic [SYMW-1:0] w_pat;
  logic            w_trig;
  logic            w_in_win;
  logic [CNTW-1:0] w_win_off;
  logic [3:0]      w_burst_m1;
  logic [SYMW-1:0] w_err;
  state_t          w_state_next;
  logic [3:0]      w_rem_next;
  logic [3:0]      w_pop;
  logic [CNTW:0]   w_bad_sum;
  logic [CNTW-1:0] w_bad_next;
  logic [CNTW-1:0] w_sym_ct_next;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right; taps land on
  // bits 0,2,3,5 and feedback enters at bit 15.
  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Candidate pattern from LFSR byte 1; if it misses every eligible bit we
  // still flip the lowest eligible bit so a trigger always corrupts something
  // (unless the mask is empty, in which case both terms are zero).
  assign w_cand    = bit_mask_i & r_lfsr[SYMW+7:8];
  assign w_low_bit = bit_mask_i & (~bit_mask_i + SYMW'(1));
  assign w_pat     = (w_cand != '0) ? w_cand : w_low_bit;

  assign w_trig    = (r_lfsr <= thresh_i);

  // Offset is only meaningful once the index is past the start, which keeps
  // the comparison free of wrap-around.
  assign w_win_off = r_sym_ct - win_start_i;
  assign w_in_win  = (r_sym_ct >= win_start_i) && (w_win_off < win_len_i);

  assign w_burst_m1 = (burst_len_i == 4'd0) ? 4'd0 : (burst_len_i - 4'd1);

  always_comb begin
    w_err        = '0;
    w_state_next = r_state;
    w_rem_next   = r_rem;
    case (mode_i)
      MODE_PASS: begin
        w_err = '0;
      end
      MODE_WINDOW: begin
        if (w_in_win) w_err = bit_mask_i;
      end
      MODE_RANDOM: begin
        if (w_trig) w_err = w_pat;
      end
      MODE_BURST: begin
        if (r_state == ST_BURST) begin
          // Inside a burst every symbol is hit and new triggers are ignored.
          w_err      = w_pat;
          w_rem_next = r_rem - 4'd1;
          if (r_rem == 4'd1) w_state_next = ST_NORMAL;
        end else if (w_trig) begin
          w_err      = w_pat;
          w_rem_next = w_burst_m1;
          if (w_burst_m1 != 4'd0) w_state_next = ST_BURST;
        end
      end
      default: w_err = '0;
    endcase
    // Leaving burst mode aborts any burst in progress.
    if (mode_i != MODE_BURST) begin
      w_state_next = ST_NORMAL;
      w_rem_next   = 4'd0;
    end
  end

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < SYMW; i++) begin
      w_pop = w_pop + {3'd0, w_err[i]};
    end
  end

  // Saturating counters: one extra bit catches the bad-bit overflow.
  assign w_bad_sum     = {1'b0, r_bad_ct} + (CNTW+1)'(w_pop);
  assign w_bad_next    = w_bad_sum[CNTW] ? CNT_MAX : w_bad_sum[CNTW-1:0];
  assign w_sym_ct_next = (r_sym_ct == CNT_MAX) ? CNT_MAX : (r_sym_ct + CNTW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr   <= SEED_EFF;
      r_state  <= ST_NORMAL;
      r_rem    <= 4'd0;
      r_valid  <= 1'b0;
      r_sym    <= '0;
      r_err    <= '0;
      r_sym_ct <= '0;
      r_bad_ct <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (clr_i) begin
        // Clear wins over a coincident symbol: it passes clean and uncounted.
        r_lfsr   <= SEED_EFF;
        r_state  <= ST_NORMAL;
        r_rem    <= 4'd0;
        r_sym_ct <= '0;
        r_bad_ct <= '0;
        r_sat    <= 1'b0;
        r_err    <= '0;
        if (valid_i) r_sym <= sym_i;
      end else if (valid_i) begin
        r_lfsr   <= w_lfsr_next;
        r_state  <= w_state_next;
        r_rem    <= w_rem_next;
        r_err    <= w_err;
        r_sym    <= sym_i ^ w_err;
        r_sym_ct <= w_sym_ct_next;
        r_bad_ct <= w_bad_next;
        r_sat    <= r_sat | (w_sym_ct_next == CNT_MAX) | (w_bad_next == CNT_MAX);
      end else begin
        // Idle cycle: sym_o holds, no error is reported, nothing advances.
        r_err <= '0;
      end
    end
  end

  assign valid_o      = r_valid;
  assign sym_o        = r_sym;
  assign err_o        = r_err;
  assign sym_ct_o     = r_sym_ct;
  assign bad_bit_ct_o = r_bad_ct;
  assign sat_o        = r_sat;

endmodule

// File: tb/tb_viterbi_err_channel.sv
module tb_viterbi_err_channel;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  sym_i;
  logic [1:0]  mode_i;
  logic [1:0]  bit_mask_i;
  logic [15:0] thresh_i;
  logic [3:0]  burst_len_i;
  logic [31:0] win_start_i;
  logic [31:0] win_len_i;
  logic        clr_i;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic [1:0]  err_o;
  logic [31:0] sym_ct_o;
  logic [31:0] bad_bit_ct_o;
  logic        sat_o;

  // Small-counter instance for saturation checks
  logic        s_valid;
  logic        s_clr;
  logic        s_valid_o;
  logic [1:0]  s_sym_o;
  logic [1:0]  s_err_o;
  logic [3:0]  s_sym_ct;
  logic [3:0]  s_bad_ct;
  logic        s_sat;

  always #5 clk = ~clk;

  viterbi_err_channel #(.SYMW(2), .CNTW(32), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
    .bit_mask_i(bit_mask_i), .thresh_i(thresh_i), .burst_len_i(burst_len_i),
    .win_start_i(win_start_i), .win_len_i(win_len_i), .clr_i(clr_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .sym_ct_o(sym_ct_o),
    .bad_bit_ct_o(bad_bit_ct_o), .sat_o(sat_o)
  );

  viterbi_err_channel #(.SYMW(2), .CNTW(4), .SEED(SEED)) u_small (
    .clk(clk), .rst(rst), .valid_i(s_valid), .sym_i(2'b00), .mode_i(2'd1),
    .bit_mask_i(2'b11), .thresh_i(16'h0000), .burst_len_i(4'd0),
    .win_start_i(4'd0), .win_len_i(4'hF), .clr_i(s_clr),
    .valid_o(s_valid_o), .sym_o(s_sym_o), .err_o(s_err_o), .sym_ct_o(s_sym_ct),
    .bad_bit_ct_o(s_bad_ct), .sat_o(s_sat)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  logic [3:0]  exp_q[$];   // {expected sym_o, expected err_o}
  logic [15:0] m_lfsr;     // reference LFSR state

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // Candidate pattern for a 2-bit symbol from LFSR value l
  function automatic logic [1:0] pat(input logic [15:0] l, input logic [1:0] mask);
    logic [1:0] p;
    p = mask & l[9:8];
    if (p == 2'b00) p = mask[0] ? 2'b01 : (mask & 2'b10);
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Drive one valid symbol; the caller supplies the hand/model expected error.
  task automatic send_sym(input logic [1:0] s, input logic [1:0] e);
    valid_i = 1'b1;
    sym_i   = s;
    exp_q.push_back({s ^ e, e});
    if (!clr_i) m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    valid_i = 1'b0;
    clr_i   = 1'b1;
    @(posedge clk);
    #1;
    clr_i  = 1'b0;
    m_lfsr = SEED;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a symbol
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        n_tests++;
        n_txn++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_out: got sym=%b err=%b, expected no output", sym_o, err_o);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if ({sym_o, err_o} !== e) begin
            n_fail++;
            $display("[TB] FAIL txn%0d: got sym=%b err=%b, expected sym=%b err=%b",
                     n_txn, sym_o, err_o, e[3:2], e[1:0]);
          end else begin
            $display("[TB] txn%0d sym=%b err=%b", n_txn, sym_o, err_o);
          end
        end
      end else begin
        n_tests++;
        if (err_o !== 2'b00) begin
          n_fail++;
          $display("[TB] FAIL idle_err: got %b, expected 00", err_o);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad_sum;
    logic [1:0] e;
    logic [1:0] r;

    rst = 1'b1; valid_i = 0; sym_i = 0; mode_i = 0; bit_mask_i = 0;
    thresh_i = 0; burst_len_i = 0; win_start_i = 0; win_len_i = 0; clr_i = 0;
    s_valid = 0; s_clr = 0;
    m_lfsr = SEED;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_sym_o",   {30'd0, sym_o},   32'd0);
    check("rst_err_o",   {30'd0, err_o},   32'd0);
    check("rst_sym_ct",  sym_ct_o,         32'd0);
    check("rst_bad_ct",  bad_bit_ct_o,     32'd0);
    check("rst_sat",     {31'd0, sat_o},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0: pass-through
    mode_i = 2'd0; bit_mask_i = 2'b11; thresh_i = 16'hFFFF;
    for (int i = 0; i < 10; i++) send_sym(2'(i), 2'b00);
    idle();
    check("m0_sym_ct", sym_ct_o, 32'd10);
    check("m0_bad_ct", bad_bit_ct_o, 32'd0);

    // Mode 1: window of 4 starting at index 0, only bit 1 eligible
    do_clr();
    check("clr_sym_ct", sym_ct_o, 32'd0);
    mode_i = 2'd1; bit_mask_i = 2'b10; win_start_i = 0; win_len_i = 4;
    for (int i = 0; i < 8; i++) send_sym(2'b00, (i < 4) ? 2'b10 : 2'b00);
    check("m1_sym_ct", sym_ct_o, 32'd8);
    check("m1_bad_ct", bad_bit_ct_o, 32'd4);

    // Mode 2: threshold 0 never triggers, 0xFFFF always triggers
    do_clr();
    mode_i = 2'd2; bit_mask_i = 2'b11; thresh_i = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      r = 2'($urandom_range(0, 3));
      send_sym(r, 2'b00);
    end
    check("m2_t0_bad_ct", bad_bit_ct_o, 32'd0);
    thresh_i = 16'hFFFF;
    bad_sum  = 0;
    for (int i = 0; i < 100; i++) begin
      e = pat(m_lfsr, 2'b11);
      bad_sum += int'(e[0]) + int'(e[1]);
      r = 2'($urandom_range(0, 3));
      send_sym(r, e);
    end
    check("m2_tmax_bad_ct", bad_bit_ct_o, 32'(bad_sum));
    check("m2_sym_ct", sym_ct_o, 32'd200);

    // Mode 3: burst of 3 triggered by the first symbol only (mask 01 => err 01)
    do_clr();
    mode_i = 2'd3; bit_mask_i = 2'b01; burst_len_i = 4'd3; thresh_i = 16'hFFFF;
    send_sym(2'b10, 2'b01);
    thresh_i = 16'h0000;
    send_sym(2'b10, 2'b01);
    send_sym(2'b11, 2'b01);
    for (int i = 0; i < 5; i++) send_sym(2'b00, 2'b00);
    check("m3_bad_ct", bad_bit_ct_o, 32'd3);

    // burst_len 0 behaves as a single-symbol error
    burst_len_i = 4'd0; thresh_i = 16'hFFFF;
    send_sym(2'b00, 2'b01);
    thresh_i = 16'h0000;
    for (int i = 0; i < 4; i++) send_sym(2'b01, 2'b00);
    check("m3_len0_bad_ct", bad_bit_ct_o, 32'd4);

    // Leaving mode 3 mid-burst aborts the burst
    burst_len_i = 4'd5; thresh_i = 16'hFFFF;
    send_sym(2'b00, 2'b01);
    thresh_i = 16'h0000;
    send_sym(2'b00, 2'b01);
    mode_i = 2'd0;
    send_sym(2'b01, 2'b00);
    mode_i = 2'd3;
    send_sym(2'b10, 2'b00);
    check("m3_abort_bad_ct", bad_bit_ct_o, 32'd6);
    check("m3_abort_sym_ct", sym_ct_o, 32'd17);

    // Clear coincident with a valid symbol: passes clean, not counted
    mode_i = 2'd1; bit_mask_i = 2'b11; win_start_i = 0; win_len_i = 32'hFFFF_FFFF;
    clr_i = 1'b1;
    send_sym(2'b01, 2'b00);
    clr_i  = 1'b0;
    m_lfsr = SEED;
    check("clrv_sym_ct", sym_ct_o, 32'd0);
    check("clrv_bad_ct", bad_bit_ct_o, 32'd0);

    // Reset in the middle of a burst (remaining = 2)
    mode_i = 2'd3; bit_mask_i = 2'b01; burst_len_i = 4'd4; thresh_i = 16'hFFFF;
    send_sym(2'b00, 2'b01);
    thresh_i = 16'h0000;
    send_sym(2'b00, 2'b01);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
    check("midrst_sym_o",   {30'd0, sym_o},   32'd0);
    check("midrst_err_o",   {30'd0, err_o},   32'd0);
    check("midrst_bad_ct",  bad_bit_ct_o,     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < 4; i++) begin
      send_sym(2'(i), 2'b00);
      idle();
    end
    check("postrst_bad_ct", bad_bit_ct_o, 32'd0);
    mode_i = 2'd2; bit_mask_i = 2'b11; thresh_i = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      e = pat(m_lfsr, 2'b11);
      send_sym(2'b00, e);
    end
    idle();
    idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Saturation with 4-bit counters
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("sat_sym_ct", {28'd0, s_sym_ct}, 32'd15);
    check("sat_bad_ct", {28'd0, s_bad_ct}, 32'd15);
    check("sat_flag",   {31'd0, s_sat},    32'd1);
    s_clr = 1'b1;
    @(posedge clk);
    #1;
    s_clr = 1'b0;
    check("satclr_sym_ct", {28'd0, s_sym_ct}, 32'd0);
    check("satclr_bad_ct", {28'd0, s_bad_ct}, 32'd0);
    check("satclr_flag",   {31'd0, s_sat},    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
